// File: rtl/dport_responder.sv
// Hart-side debug-port endpoint: decodes one abstract register access, runs it
// through the CSR port or the integer register file, and returns one response.
//
// state    | meaning
// IDLE     | ready for a new dport request
// CSR_REQ  | presenting CSR request, waiting for acceptance
// CSR_RESP | waiting for the CSR response
// GPR_RD   | single-cycle GPR access (read sample or write strobe)
// RESP     | holding the dport response until consumed
module dport_responder #(
  parameter int RISCV_ARCH  = 64,
  parameter int CSR_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dport_req_valid,
  output logic                  o_dport_req_ready,
  input  logic                  i_dport_write,
  input  logic [RISCV_ARCH-1:0] i_dport_addr,
  input  logic [RISCV_ARCH-1:0] i_dport_wdata,
  input  logic [2:0]            i_dport_size,
  output logic                  o_dport_resp_valid,
  input  logic                  i_dport_resp_ready,
  output logic                  o_dport_resp_error,
  output logic [RISCV_ARCH-1:0] o_dport_rdata,
  input  logic                  i_halted,
  output logic                  o_csr_req_valid,
  input  logic                  i_csr_req_ready,
  output logic                  o_csr_req_write,
  output logic [11:0]           o_csr_req_addr,
  output logic [RISCV_ARCH-1:0] o_csr_req_data,
  input  logic                  i_csr_resp_valid,
  output logic                  o_csr_resp_ready,
  input  logic [RISCV_ARCH-1:0] i_csr_resp_data,
  input  logic                  i_csr_resp_exception,
  output logic [4:0]            o_ireg_addr,
  output logic                  o_ireg_wena,
  output logic [RISCV_ARCH-1:0] o_ireg_wdata,
  input  logic [RISCV_ARCH-1:0] i_ireg_rdata
);

  localparam int CW = $clog2(CSR_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(CSR_TIMEOUT - 1);
  localparam logic [RISCV_ARCH-1:0] LO32 = RISCV_ARCH'(64'hFFFF_FFFF);

  typedef enum logic [2:0] {IDLE, CSR_REQ, CSR_RESP, GPR_RD, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic                    wr_q, wide_q, err_q;
  logic [11:0]             addr_q;
  logic [RISCV_ARCH-1:0]   wdata_q, rdata_q, rmask;
  logic                    accept, size_ok, is_csr, is_gpr, to_hit;
  logic                    unused_addr_hi;

  assign size_ok = (i_dport_size == 3'd2) || (i_dport_size == 3'd3);
  assign is_csr  = i_dport_addr[15:12] == 4'h0;
  assign is_gpr  = i_dport_addr[15:5] == 11'h080;
  assign to_hit  = cnt_q == TO_LAST;
  assign rmask   = wide_q ? '1 : LO32;
  // Register numbers only occupy the low 16 bits of the address.
  assign unused_addr_hi = ^i_dport_addr[RISCV_ARCH-1:16];

  assign o_dport_rdata      = rdata_q;
  assign o_dport_resp_error = err_q;
  assign o_csr_req_write    = wr_q;
  assign o_csr_req_addr     = addr_q;
  assign o_csr_req_data     = wdata_q;
  assign o_ireg_addr        = addr_q[4:0];
  assign o_ireg_wdata       = wdata_q;

  always_comb begin
    state_d            = state_q;
    accept             = 1'b0;
    o_dport_req_ready  = (state_q == IDLE);
    o_dport_resp_valid = (state_q == RESP);
    o_csr_req_valid    = (state_q == CSR_REQ);
    o_csr_resp_ready   = (state_q == CSR_RESP);
    o_ireg_wena        = (state_q == GPR_RD) && wr_q;
    case (state_q)
      IDLE: begin
        if (i_dport_req_valid) begin
          accept = 1'b1;
          if (!size_ok)                state_d = RESP;
          else if (is_csr)             state_d = CSR_REQ;
          else if (is_gpr && i_halted) state_d = GPR_RD;
          else                         state_d = RESP;
        end
      end
      CSR_REQ: begin
        if (i_csr_req_ready)  state_d = CSR_RESP;
        else if (to_hit)      state_d = RESP;
      end
      CSR_RESP: begin
        if (i_csr_resp_valid || to_hit) state_d = RESP;
      end
      GPR_RD:  state_d = RESP;
      RESP: begin
        if (i_dport_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wide_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // The timeout window restarts on every state change.
      if (state_d != state_q) cnt_q <= '0;
      else if (state_q == CSR_REQ || state_q == CSR_RESP) cnt_q <= cnt_q + CW'(1);
      if (accept) begin
        wr_q    <= i_dport_write;
        wide_q  <= (i_dport_size == 3'd3);
        addr_q  <= i_dport_addr[11:0];
        wdata_q <= i_dport_wdata & ((i_dport_size == 3'd3) ? '1 : LO32);
        rdata_q <= '0;
        err_q   <= (state_d == RESP);
      end
      case (state_q)
        GPR_RD: begin
          if (!wr_q) rdata_q <= i_ireg_rdata & rmask;
        end
        CSR_REQ: begin
          if (!i_csr_req_ready && to_hit) err_q <= 1'b1;
        end
        CSR_RESP: begin
          if (i_csr_resp_valid) begin
            err_q <= i_csr_resp_exception;
            if (!wr_q) rdata_q <= i_csr_resp_data & rmask;
          end else if (to_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
